// File: rtl/sr_cmd_pkg.sv
// ============================================================================
// Module   : sr_cmd_pkg
// Purpose  : Shared FSM state type and counter-width helpers for sr_cmd_gen.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Width of a counter able to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DB_CYCLES_DEF  = 4;
    localparam int GAP_CYCLES_DEF = 2;
    localparam int DB_CNT_W       = cnt_w(DB_CYCLES_DEF);
    localparam int GAP_CNT_W      = cnt_w(GAP_CYCLES_DEF);

endpackage

`default_nettype wire

// File: rtl/sr_debounce.sv
// ============================================================================
// Module   : sr_debounce
// Purpose  : Optional 2-flop synchroniser (SR_CMD_GEN_SYNC_EN), debouncer and
//            one-cycle rising-edge strobe of the accepted level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int            CW       = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sample;
    logic          db;
    logic [CW-1:0] cnt;

`ifdef SR_CMD_GEN_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    assign sample = sync[1];
`else
    assign sample = raw;
`endif

    // A sample matching db restarts the count, so short glitches never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sample == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db   <= sample;
                cnt  <= '0;
                rise <= sample;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sr_cmd_gen.sv
// ============================================================================
// Module   : sr_cmd_gen
// Purpose  : Debounced set/reset request front-end producing mutually
//            exclusive, gap-spaced s/r pulses. Macro: SR_CMD_GEN_SYNC_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int RESET_PRIO = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_in,
    input  logic reset_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int            GW       = cnt_w(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam bit            NO_GAP   = (GAP_CYCLES == 0);

    logic rise_s, rise_r;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (set_in),
        .rise  (rise_s)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (reset_in),
        .rise  (rise_r)
    );

    state_t        state, next_state;
    logic [GW-1:0] gap_cnt, next_gap;
    logic          pend_s, pend_r, tie, older_r;
    logic          pend_s_n, pend_r_n, tie_n, older_r_n;
    logic          s_n, r_n, conf_n, busy_n;
    logic          clr_s, clr_r, ready;
    logic          keep_s, keep_r, new_s, new_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
            tie      <= 1'b0;
            older_r  <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= next_state;
            gap_cnt  <= next_gap;
            pend_s   <= pend_s_n;
            pend_r   <= pend_r_n;
            tie      <= tie_n;
            older_r  <= older_r_n;
            s        <= s_n;
            r        <= r_n;
            busy     <= busy_n;
            conflict <= conf_n;
        end
    end

    // A new request may issue on the first edge at which the gap has expired.
    assign ready = (state == IDLE)
                || (state == ISSUE && NO_GAP)
                || (state == GAP && gap_cnt == GAP_LAST);

    always_comb begin
        next_state = state;
        next_gap   = gap_cnt;
        s_n        = 1'b0;
        r_n        = 1'b0;
        conf_n     = 1'b0;
        clr_s      = 1'b0;
        clr_r      = 1'b0;

        case (state)
            IDLE: ;
            ISSUE: begin
                if (NO_GAP) begin
                    next_state = IDLE;
                end else begin
                    next_state = GAP;
                    next_gap   = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) next_state = IDLE;
                else                     next_gap   = gap_cnt + 1'b1;
            end
            default: next_state = IDLE;
        endcase

        if (ready) begin
            if (pend_s && pend_r) begin
                if (tie) begin
                    conf_n = 1'b1;
                    clr_s  = 1'b1;
                    clr_r  = 1'b1;
                    if (RESET_PRIO != 0) r_n = 1'b1;
                    else                 s_n = 1'b1;
                end else if (older_r) begin
                    r_n   = 1'b1;
                    clr_r = 1'b1;
                end else begin
                    s_n   = 1'b1;
                    clr_s = 1'b1;
                end
            end else if (pend_s) begin
                s_n   = 1'b1;
                clr_s = 1'b1;
            end else if (pend_r) begin
                r_n   = 1'b1;
                clr_r = 1'b1;
            end
            if (s_n || r_n) next_state = ISSUE;
        end

        busy_n = (next_state != IDLE);
    end

    // Pending flags with arrival-order tracking; only same-edge arrivals tie.
    always_comb begin
        keep_s    = pend_s & ~clr_s;
        keep_r    = pend_r & ~clr_r;
        new_s     = rise_s & ~keep_s;
        new_r     = rise_r & ~keep_r;
        pend_s_n  = keep_s | rise_s;
        pend_r_n  = keep_r | rise_r;
        tie_n     = tie;
        older_r_n = older_r;
        if (new_s && new_r) begin
            tie_n = 1'b1;
        end else if (new_s) begin
            tie_n     = 1'b0;
            older_r_n = keep_r;
        end else if (new_r) begin
            tie_n     = 1'b0;
            older_r_n = ~keep_s;
        end
    end

endmodule

`default_nettype wire
